// File: rtl/hkspi_pkg.sv
// Shared constants for the housekeeping SPI slave: command codes, register map,
// register reset values and the serial-protocol state encoding.
package hkspi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_RW    = 8'hC0;

    localparam logic [7:0] REG_MFGR_HI   = 8'd1;
    localparam logic [7:0] REG_MFGR_LO   = 8'd2;
    localparam logic [7:0] REG_PROD      = 8'd3;
    localparam logic [7:0] REG_USER_HI   = 8'd4;
    localparam logic [7:0] REG_USER_MID  = 8'd5;
    localparam logic [7:0] REG_USER_LO   = 8'd6;
    localparam logic [7:0] REG_EXTRST    = 8'd7;
    localparam logic [7:0] REG_PLLENA    = 8'd8;
    localparam logic [7:0] REG_PLLBYP    = 8'd9;
    localparam logic [7:0] REG_IRQ       = 8'd10;
    localparam logic [7:0] REG_CPURST    = 8'd11;
    localparam logic [7:0] REG_TRAP      = 8'd12;
    localparam logic [7:0] REG_TRIM_HI   = 8'd13;
    localparam logic [7:0] REG_TRIM_MID  = 8'd14;
    localparam logic [7:0] REG_TRIM_LO   = 8'd15;
    localparam logic [7:0] REG_PLLOUTDIV = 8'd16;
    localparam logic [7:0] REG_PLLDIV_HI = 8'd17;
    localparam logic [7:0] REG_PLLDIV_LO = 8'd18;

    localparam logic        RST_EXTRST    = 1'b0;
    localparam logic [7:0]  RST_PLLENA    = 8'h02;
    localparam logic [7:0]  RST_PLLBYP    = 8'h01;
    localparam logic        RST_IRQ       = 1'b0;
    localparam logic        RST_CPURST    = 1'b0;
    localparam logic [23:0] RST_TRIM      = 24'hFFEFFF;
    localparam logic [7:0]  RST_PLLOUTDIV = 8'h03;
    localparam logic [15:0] RST_PLLDIV    = 16'h1204;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_NOP
    } hkspi_state_e;

endpackage

// File: rtl/hkspi_slave.sv
// SPI mode-0 slave oversampled by the system clock: synchronisers, edge detect,
// command/address/data sequencing and the byte-wide register-file handshake.
module hkspi_slave
    import hkspi_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    input  logic [7:0] rdata,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       sdo,
    output logic       sdo_enb
);

    logic [1:0]   sck_sync_q, csb_sync_q, sdi_sync_q;
    logic         sck_prev_q, csb_prev_q;
    hkspi_state_e state_q, state_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [6:0]   shin_q, shin_d;
    logic [6:0]   shout_q, shout_d;
    logic [7:0]   addr_q, addr_d;
    logic         rd_mode_q, rd_mode_d;
    logic         wr_mode_q, wr_mode_d;
    logic         load_pend_q, load_pend_d;
    logic         sdo_q, sdo_d;
    logic         sdo_enb_q, sdo_enb_d;

    logic       sck_s, csb_s, sdi_s;
    logic       sck_rise, sck_fall, csb_start;
    logic [7:0] in_byte;

    assign sck_s     = sck_sync_q[1];
    assign csb_s     = csb_sync_q[1];
    assign sdi_s     = sdi_sync_q[1];
    assign sck_rise  = !csb_s && sck_s && !sck_prev_q;
    assign sck_fall  = !csb_s && !sck_s && sck_prev_q;
    assign csb_start = csb_prev_q && !csb_s;
    assign in_byte   = {shin_q, sdi_s};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync_q  <= 2'b00;
            csb_sync_q  <= 2'b11;
            sdi_sync_q  <= 2'b00;
            sck_prev_q  <= 1'b0;
            csb_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            shin_q      <= 7'd0;
            shout_q     <= 7'd0;
            addr_q      <= 8'd0;
            rd_mode_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
            load_pend_q <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_enb_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck};
            csb_sync_q  <= {csb_sync_q[0], csb};
            sdi_sync_q  <= {sdi_sync_q[0], sdi};
            sck_prev_q  <= sck_s;
            csb_prev_q  <= csb_s;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            addr_q      <= addr_d;
            rd_mode_q   <= rd_mode_d;
            wr_mode_q   <= wr_mode_d;
            load_pend_q <= load_pend_d;
            sdo_q       <= sdo_d;
            sdo_enb_q   <= sdo_enb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        addr_d      = addr_q;
        rd_mode_d   = rd_mode_q;
        wr_mode_d   = wr_mode_q;
        load_pend_d = load_pend_q;
        sdo_d       = sdo_q;
        sdo_enb_d   = sdo_enb_q;
        wr_strobe   = 1'b0;
        rd_strobe   = 1'b0;

        if (csb_s) begin
            state_d     = ST_IDLE;
            bitcnt_d    = 3'd0;
            load_pend_d = 1'b0;
            sdo_enb_d   = 1'b1;
        end else if (csb_start) begin
            state_d  = ST_CMD;
            bitcnt_d = 3'd0;
        end else begin
            if (sck_rise && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA)) begin
                shin_d   = in_byte[6:0];
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    case (state_q)
                        ST_CMD: begin
                            case (in_byte)
                                CMD_WRITE: begin wr_mode_d = 1'b1; rd_mode_d = 1'b0; state_d = ST_ADDR; end
                                CMD_READ:  begin wr_mode_d = 1'b0; rd_mode_d = 1'b1; state_d = ST_ADDR; end
                                CMD_RW:    begin wr_mode_d = 1'b1; rd_mode_d = 1'b1; state_d = ST_ADDR; end
                                default:   state_d = ST_NOP;
                            endcase
                        end
                        ST_ADDR: begin
                            addr_d      = in_byte;
                            load_pend_d = rd_mode_q;
                            state_d     = ST_DATA;
                        end
                        default: begin
                            // The byte completes here: commit it, then advance so the
                            // following falling edge prefetches the next address.
                            wr_strobe   = wr_mode_q;
                            addr_d      = addr_q + 8'd1;
                            load_pend_d = rd_mode_q;
                        end
                    endcase
                end
            end

            if (sck_fall && state_q == ST_DATA && rd_mode_q) begin
                if (load_pend_q) begin
                    rd_strobe   = 1'b1;
                    sdo_d       = rdata[7];
                    shout_d     = rdata[6:0];
                    sdo_enb_d   = 1'b0;
                    load_pend_d = 1'b0;
                end else begin
                    sdo_d   = shout_q[6];
                    shout_d = {shout_q[5:0], 1'b0};
                end
            end
        end
    end

    assign addr    = addr_q;
    assign wdata   = in_byte;
    assign sdo     = sdo_q;
    assign sdo_enb = sdo_enb_q;

endmodule

// File: rtl/housekeeping_spi.sv
// Housekeeping register file (ID, PLL, DCO trim, reset controls) reachable from
// an off-chip host through the hkspi_slave serial interface.
module housekeeping_spi
    import hkspi_pkg::*;
#(
    parameter logic [11:0] MFGR_ID = 12'h456,
    parameter logic [7:0]  PROD_ID = 8'h10,
    parameter logic [23:0] USER_ID = 24'h000000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        sck,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_enb,
    input  logic        trap,
    output logic        ext_reset,
    output logic [7:0]  pll_ena,
    output logic [7:0]  pll_bypass,
    output logic        irq_spi,
    output logic        cpu_reset,
    output logic [23:0] dco_trim,
    output logic [7:0]  pll_outdiv,
    output logic [15:0] pll_div
);

    logic [7:0] addr, wdata, rdata, rd_mux;
    logic       wr_strobe, rd_strobe;

    logic        ext_reset_q, ext_reset_d;
    logic [7:0]  pll_ena_q, pll_ena_d;
    logic [7:0]  pll_bypass_q, pll_bypass_d;
    logic        irq_spi_q, irq_spi_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic [23:0] dco_trim_q, dco_trim_d;
    logic [7:0]  pll_outdiv_q, pll_outdiv_d;
    logic [15:0] pll_div_q, pll_div_d;

    hkspi_slave u_slave (
        .clock     (clock),
        .resetb    (resetb),
        .sck       (sck),
        .csb       (csb),
        .sdi       (sdi),
        .rdata     (rdata),
        .addr      (addr),
        .wdata     (wdata),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .sdo       (sdo),
        .sdo_enb   (sdo_enb)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ext_reset_q  <= RST_EXTRST;
            pll_ena_q    <= RST_PLLENA;
            pll_bypass_q <= RST_PLLBYP;
            irq_spi_q    <= RST_IRQ;
            cpu_reset_q  <= RST_CPURST;
            dco_trim_q   <= RST_TRIM;
            pll_outdiv_q <= RST_PLLOUTDIV;
            pll_div_q    <= RST_PLLDIV;
        end else begin
            ext_reset_q  <= ext_reset_d;
            pll_ena_q    <= pll_ena_d;
            pll_bypass_q <= pll_bypass_d;
            irq_spi_q    <= irq_spi_d;
            cpu_reset_q  <= cpu_reset_d;
            dco_trim_q   <= dco_trim_d;
            pll_outdiv_q <= pll_outdiv_d;
            pll_div_q    <= pll_div_d;
        end
    end

    always_comb begin
        ext_reset_d  = ext_reset_q;
        pll_ena_d    = pll_ena_q;
        pll_bypass_d = pll_bypass_q;
        irq_spi_d    = irq_spi_q;
        cpu_reset_d  = cpu_reset_q;
        dco_trim_d   = dco_trim_q;
        pll_outdiv_d = pll_outdiv_q;
        pll_div_d    = pll_div_q;
        if (wr_strobe) begin
            case (addr)
                REG_EXTRST:    ext_reset_d           = wdata[0];
                REG_PLLENA:    pll_ena_d             = wdata;
                REG_PLLBYP:    pll_bypass_d          = wdata;
                REG_IRQ:       irq_spi_d             = wdata[0];
                REG_CPURST:    cpu_reset_d           = wdata[0];
                REG_TRIM_HI:   dco_trim_d[23:16]     = wdata;
                REG_TRIM_MID:  dco_trim_d[15:8]      = wdata;
                REG_TRIM_LO:   dco_trim_d[7:0]       = wdata;
                REG_PLLOUTDIV: pll_outdiv_d          = wdata;
                REG_PLLDIV_HI: pll_div_d[15:8]       = wdata;
                REG_PLLDIV_LO: pll_div_d[7:0]        = wdata;
                default:       ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            REG_MFGR_HI:   rd_mux = {4'h0, MFGR_ID[11:8]};
            REG_MFGR_LO:   rd_mux = MFGR_ID[7:0];
            REG_PROD:      rd_mux = PROD_ID;
            REG_USER_HI:   rd_mux = USER_ID[23:16];
            REG_USER_MID:  rd_mux = USER_ID[15:8];
            REG_USER_LO:   rd_mux = USER_ID[7:0];
            REG_EXTRST:    rd_mux = {7'd0, ext_reset_q};
            REG_PLLENA:    rd_mux = pll_ena_q;
            REG_PLLBYP:    rd_mux = pll_bypass_q;
            REG_IRQ:       rd_mux = {7'd0, irq_spi_q};
            REG_CPURST:    rd_mux = {7'd0, cpu_reset_q};
            REG_TRAP:      rd_mux = {7'd0, trap};
            REG_TRIM_HI:   rd_mux = dco_trim_q[23:16];
            REG_TRIM_MID:  rd_mux = dco_trim_q[15:8];
            REG_TRIM_LO:   rd_mux = dco_trim_q[7:0];
            REG_PLLOUTDIV: rd_mux = pll_outdiv_q;
            REG_PLLDIV_HI: rd_mux = pll_div_q[15:8];
            REG_PLLDIV_LO: rd_mux = pll_div_q[7:0];
            default:       rd_mux = 8'h00;
        endcase
    end

    // Read data is only meaningful while the slave is loading its shift-out register.
    assign rdata = rd_strobe ? rd_mux : 8'h00;

    assign ext_reset  = ext_reset_q;
    assign pll_ena    = pll_ena_q;
    assign pll_bypass = pll_bypass_q;
    assign irq_spi    = irq_spi_q;
    assign cpu_reset  = cpu_reset_q;
    assign dco_trim   = dco_trim_q;
    assign pll_outdiv = pll_outdiv_q;
    assign pll_div    = pll_div_q;

endmodule

// File: tb/tb_housekeeping_spi.sv
// Directed bench for housekeeping_spi: the host side pushes expected read bytes
// into a queue and a separate SDO monitor pops and compares them.
module tb_housekeeping_spi;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        sck = 1'b0;
    logic        csb = 1'b1;
    logic        sdi = 1'b0;
    logic        trap = 1'b0;
    logic        sdo, sdo_enb, ext_reset, irq_spi, cpu_reset;
    logic [7:0]  pll_ena, pll_bypass, pll_outdiv;
    logic [23:0] dco_trim;
    logic [15:0] pll_div;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    housekeeping_spi dut (
        .clock      (clock),
        .resetb     (resetb),
        .sck        (sck),
        .csb        (csb),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_enb    (sdo_enb),
        .trap       (trap),
        .ext_reset  (ext_reset),
        .pll_ena    (pll_ena),
        .pll_bypass (pll_bypass),
        .irq_spi    (irq_spi),
        .cpu_reset  (cpu_reset),
        .dco_trim   (dco_trim),
        .pll_outdiv (pll_outdiv),
        .pll_div    (pll_div)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic cs_start();
        csb = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        csb = 1'b1;
        #200;
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = b[i];
            #50 sck = 1'b1;
            #50 sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        xfer_bits(b, 8);
    endtask

    // Issue a read stream and queue the bytes the host expects to see.
    task automatic read_stream(input logic [7:0] start, input logic [7:0] exp_bytes[]);
        cs_start();
        xfer(8'h40);
        xfer(start);
        foreach (exp_bytes[k]) begin
            exp_q.push_back(exp_bytes[k]);
            xfer(8'h00);
        end
        cs_end();
    endtask

    task automatic write_stream(input logic [7:0] start, input logic [7:0] data[]);
        cs_start();
        xfer(8'h80);
        xfer(start);
        foreach (data[k]) xfer(data[k]);
        cs_end();
    endtask

    // SDO monitor: assembles bytes on host sampling edges while the pad is enabled.
    initial begin
        logic [7:0] mon_sh;
        logic [7:0] e;
        int mon_cnt;
        mon_sh = 8'h00;
        mon_cnt = 0;
        forever begin
            @(posedge sck or posedge csb);
            if (csb) begin
                mon_cnt = 0;
            end else if (!sdo_enb) begin
                mon_sh = {mon_sh[6:0], sdo};
                mon_cnt++;
                if (mon_cnt == 8) begin
                    mon_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rd_byte", {16'h0, mon_sh}, 24'hxxxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_byte", {16'h0, mon_sh}, {16'h0, e});
                    end
                end
            end
        end
    end

    initial begin
        #52;
        check("rst_sdo_enb", 24'(sdo_enb), 24'h1);
        check("rst_sdo", 24'(sdo), 24'h0);
        check("rst_ext_reset", 24'(ext_reset), 24'h0);
        check("rst_pll_ena", 24'(pll_ena), 24'h02);
        check("rst_pll_bypass", 24'(pll_bypass), 24'h01);
        check("rst_irq_cpu", {22'h0, irq_spi, cpu_reset}, 24'h0);
        check("rst_dco_trim", dco_trim, 24'hFFEFFF);
        check("rst_pll_outdiv", 24'(pll_outdiv), 24'h03);
        check("rst_pll_div", 24'(pll_div), 24'h1204);
        #8 resetb = 1'b1;
        #100;

        // Product ID read, with pad-enable framing
        cs_start();
        xfer(8'h40);
        check("id_enb_cmd", 24'(sdo_enb), 24'h1);
        xfer(8'h03);
        exp_q.push_back(8'h10);
        xfer(8'h00);
        check("id_enb_data", 24'(sdo_enb), 24'h0);
        cs_end();
        check("id_enb_after", 24'(sdo_enb), 24'h1);

        read_stream(8'h00, '{8'h00, 8'h04, 8'h56, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF,
                             8'h03, 8'h12, 8'h04});

        write_stream(8'h07, '{8'h01});
        check("ext_reset_set", 24'(ext_reset), 24'h1);
        write_stream(8'h07, '{8'h00});
        check("ext_reset_clr", 24'(ext_reset), 24'h0);
        read_stream(8'h07, '{8'h00});

        write_stream(8'h0D, '{8'hAA, 8'hBB, 8'hCC});
        check("dco_trim_wr", dco_trim, 24'hAABBCC);
        read_stream(8'h0D, '{8'hAA, 8'hBB, 8'hCC});

        write_stream(8'h11, '{8'h34, 8'h56});
        check("pll_div_wr", 24'(pll_div), 24'h3456);

        // Abort mid byte: the partial byte must not land
        cs_start();
        xfer(8'h80);
        xfer(8'h10);
        xfer_bits(8'h55, 4);
        cs_end();
        check("abort_outdiv", 24'(pll_outdiv), 24'h03);

        write_stream(8'h03, '{8'h55});
        read_stream(8'h03, '{8'h10});
        trap = 1'b1;
        read_stream(8'h0C, '{8'h01});
        trap = 1'b0;

        // Unmapped addresses swallow writes and read as zero
        write_stream(8'h13, '{8'h77});
        read_stream(8'h13, '{8'h00});

        // Unknown command: nothing drives SDO and nothing is written
        cs_start();
        xfer(8'h20);
        xfer(8'h08);
        xfer(8'h55);
        check("noop_enb", 24'(sdo_enb), 24'h1);
        cs_end();
        check("noop_pll_ena", 24'(pll_ena), 24'h02);

        // Simultaneous read/write across the 255 -> 0 wrap
        cs_start();
        xfer(8'hC0);
        xfer(8'hFF);
        exp_q.push_back(8'h00);
        xfer(8'h11);
        exp_q.push_back(8'h00);
        xfer(8'h22);
        cs_end();
        check("rw_wrap_pll_ena", 24'(pll_ena), 24'h02);
        check("rw_wrap_pll_div", 24'(pll_div), 24'h3456);
        read_stream(8'h00, '{8'h00});
        read_stream(8'hFF, '{8'h00, 8'h00, 8'h04});

        check("sb_drain", 24'(exp_q.size()), 24'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
